xd_pacer: RTL and testbench

Source-domain event pacer that sits directly upstream of the toggle-based pulse synchroniser. It accepts event requests at any rate, queues them as a count, and emits single-cycle flag pulses spaced at least GAP cycles apart. The spacing guarantees the destination domain resolves every toggle, so no event is lost in the crossing. Backlog beyond counter capacity is dropped and flagged.

---
 rtl/xd_pacer_pkg.sv | 19 +
 rtl/xd_pacer.sv | 108 ++++++++++
 tb/tb_xd_pacer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/xd_pacer_pkg.sv
// xd_pacer_pkg: shared types and helpers for the xd_pacer event pacer.
//   pace_state_e  : READY (spacing timer idle) / HOLD (spacing timer running)
//   GAP_CNT_W     : width of the spacing timer (covers GAP up to 255)
//   decode_state(): derives the pacer phase from the spacing timer value
package xd_pacer_pkg;

  localparam int GAP_CNT_W = 8;

  typedef enum logic {
    ST_READY = 1'b0,
    ST_HOLD  = 1'b1
  } pace_state_e;

  // The phase is not stored separately: a running timer means HOLD.
  function automatic pace_state_e decode_state(input logic [GAP_CNT_W-1:0] gap_cnt);
    return (gap_cnt == '0) ? ST_READY : ST_HOLD;
  endfunction

endpackage

// File: rtl/xd_pacer.sv
// xd_pacer: source-domain event pacer feeding a toggle pulse synchroniser.
// Accepts event requests at any rate, keeps a count of the backlog and
// emits single-cycle flag pulses at least GAP cycles apart so the
// destination domain resolves every toggle. Backlog beyond 2^CNT_W-1 is
// dropped and reported through a sticky overflow flag.
//
// Parameters:
//   GAP   : minimum cycles between consecutive flag_out rising edges (2..255)
//   CNT_W : pending-event counter width
// Ports:
//   clk      in   source-domain clock
//   rst      in   asynchronous active-high reset
//   evt_in   in   event request, one event per cycle sampled high
//   ovf_clr  in   clears the sticky overflow flag
//   flag_out out  registered one-cycle pulse to the synchroniser
//   pending  out  accepted-but-not-emitted event count
//   overflow out  sticky, set when an event is dropped
//   busy     out  backlog non-empty, spacing timer running or pulse out
module xd_pacer
  import xd_pacer_pkg::*;
#(
  parameter int GAP   = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             evt_in,
  input  logic             ovf_clr,
  output logic             flag_out,
  output logic [CNT_W-1:0] pending,
  output logic             overflow,
  output logic             busy
);

  localparam logic [CNT_W-1:0]     PEND_MAX   = '1;
  localparam logic [GAP_CNT_W-1:0] GAP_RELOAD = GAP_CNT_W'(GAP - 1);

  generate
    if (GAP < 2 || GAP > 255) begin : g_gap_chk
      $fatal(1, "xd_pacer: GAP=%0d outside legal range 2..255", GAP);
    end
    if (CNT_W < 1) begin : g_cnt_chk
      $fatal(1, "xd_pacer: CNT_W=%0d must be at least 1", CNT_W);
    end
  endgenerate

  logic [CNT_W-1:0]     pend_q,    pend_d;
  logic [GAP_CNT_W-1:0] gap_cnt_q, gap_cnt_d;
  logic                 ovf_q,     ovf_d;
  logic                 flag_q;
  logic                 fire;
  logic                 drop;
  pace_state_e          state;

  // The spacing timer is the state register; the phase is decoded from it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q    <= '0;
      gap_cnt_q <= '0;
      ovf_q     <= 1'b0;
      flag_q    <= 1'b0;
    end else begin
      pend_q    <= pend_d;
      gap_cnt_q <= gap_cnt_d;
      ovf_q     <= ovf_d;
      flag_q    <= fire;
    end
  end

  always_comb begin
    state     = decode_state(gap_cnt_q);
    fire      = 1'b0;
    drop      = 1'b0;
    pend_d    = pend_q;
    gap_cnt_d = gap_cnt_q;
    ovf_d     = ovf_q;

    case (state)
      // A fresh event with an empty backlog fires directly, bypassing pend.
      ST_READY: fire = (pend_q != '0) || evt_in;
      ST_HOLD:  gap_cnt_d = gap_cnt_q - GAP_CNT_W'(1);
      default:  ;
    endcase

    // Reloading with GAP-1 puts the next READY cycle exactly GAP cycles
    // after this one, so back-to-back pulses land GAP cycles apart.
    if (fire) gap_cnt_d = GAP_RELOAD;

    // Backlog: +evt_in -fire. An event arriving while firing replaces the
    // one leaving, so a full counter only drops when nothing fires.
    if (evt_in && !fire) begin
      if (pend_q == PEND_MAX) drop = 1'b1;
      else                    pend_d = pend_q + CNT_W'(1);
    end else if (!evt_in && fire) begin
      pend_d = pend_q - CNT_W'(1);
    end

    // A drop in the same cycle as a clear must stay visible.
    if (drop)         ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  assign flag_out = flag_q;
  assign pending  = pend_q;
  assign overflow = ovf_q;
  assign busy     = (pend_q != '0) || (gap_cnt_q != '0) || flag_q;

endmodule

// File: tb/tb_xd_pacer.sv
// Self-checking bench for xd_pacer. The model tracks events as a schedule of
// expected pulse times (each accepted event gets max(now+1, last+GAP)),
// derives pending/busy/overflow from that schedule, and the scoreboard
// queue of pulse times is consumed as the DUT emits flags.
module tb_xd_pacer;

  localparam int PMAX = 7;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       evt1 = 1'b0, clr1 = 1'b0, evt2 = 1'b0, clr2 = 1'b0;
  logic       flag1, ovf1, busy1, flag2, ovf2, busy2;
  logic [2:0] pend1, pend2;

  xd_pacer #(.GAP(4), .CNT_W(3)) u_dut (
    .clk(clk), .rst(rst), .evt_in(evt1), .ovf_clr(clr1),
    .flag_out(flag1), .pending(pend1), .overflow(ovf1), .busy(busy1)
  );

  xd_pacer #(.GAP(2), .CNT_W(3)) u_dut2 (
    .clk(clk), .rst(rst), .evt_in(evt2), .ovf_clr(clr2),
    .flag_out(flag2), .pending(pend2), .overflow(ovf2), .busy(busy2)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // model / scoreboard state
  int sb[$];
  int last_p = -1000;
  bit m_ovf  = 1'b0;
  int exp_pend;
  bit exp_busy, exp_ovf;

  task automatic model_reset();
    sb.delete();
    last_p = -1000;
    m_ovf  = 1'b0;
  endtask

  task automatic do_reset();
    evt1 = 1'b0; clr1 = 1'b0; evt2 = 1'b0; clr2 = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  // Computes expectations for cycle c, then applies this cycle's stimulus
  // to the model and to the DUT selected by g.
  task automatic drive_cycle(input int c, input int g, input bit e, input bit clr);
    int  n;
    bit  drop;
    exp_pend = 0;
    foreach (sb[i]) if (sb[i] > c) exp_pend++;
    exp_busy = (c <= last_p + g - 2);
    exp_ovf  = m_ovf;
    drop = 1'b0;
    if (e) begin
      n = 0;
      foreach (sb[i]) if (sb[i] > c + 1) n++;
      if (n >= PMAX) drop = 1'b1;
      else begin
        last_p = (last_p + g > c + 1) ? last_p + g : c + 1;
        sb.push_back(last_p);
      end
    end
    if (drop)     m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (g == 2) begin evt2 = e; clr2 = clr; end
    else        begin evt1 = e; clr1 = clr; end
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    n_chk++; if (flag1 !== 1'b0)  $display("FAIL reset.flag got=%0b exp=0", flag1);  else n_pass++;
    n_chk++; if (pend1 !== 3'd0)  $display("FAIL reset.pending got=%0d exp=0", pend1); else n_pass++;
    n_chk++; if (ovf1 !== 1'b0)   $display("FAIL reset.overflow got=%0b exp=0", ovf1); else n_pass++;
    n_chk++; if (busy1 !== 1'b0)  $display("FAIL reset.busy got=%0b exp=0", busy1);   else n_pass++;
    n_chk++; if (busy2 !== 1'b0)  $display("FAIL reset.busy2 got=%0b exp=0", busy2);  else n_pass++;
    do_reset();
  endtask

  // Generic GAP=4 window: evt high on [e_lo,e_hi], ovf_clr at clr_a/clr_b.
  task automatic run_window(input string nm, input int ncyc, input int e_lo, input int e_hi,
                            input int e_lo2, input int e_hi2, input int clr_a, input int clr_b,
                            output int npl);
    npl = 0;
    for (int c = 0; c < ncyc; c++) begin
      drive_cycle(c, 4, (c >= e_lo && c <= e_hi) || (c >= e_lo2 && c <= e_hi2),
                  (c == clr_a) || (c == clr_b));
      @(negedge clk);
      npl += int'(flag1);
      n_chk++;
      if (sb.size() != 0 && sb[0] == c) begin
        sb.delete(0);
        if (flag1 !== 1'b1) $display("FAIL %s.flag c=%0d got=%0b exp=1", nm, c, flag1); else n_pass++;
      end else begin
        if (flag1 !== 1'b0) $display("FAIL %s.flag c=%0d got=%0b exp=0", nm, c, flag1); else n_pass++;
      end
      n_chk++; if (pend1 !== 3'(exp_pend)) $display("FAIL %s.pending c=%0d got=%0d exp=%0d", nm, c, pend1, exp_pend); else n_pass++;
      n_chk++; if (busy1 !== exp_busy) $display("FAIL %s.busy c=%0d got=%0b exp=%0b", nm, c, busy1, exp_busy); else n_pass++;
      n_chk++; if (ovf1 !== exp_ovf) $display("FAIL %s.overflow c=%0d got=%0b exp=%0b", nm, c, ovf1, exp_ovf); else n_pass++;
      @(posedge clk); #1;
    end
    n_chk++; if (sb.size() != 0) $display("FAIL %s.missing got=%0d exp=0 pulses outstanding", nm, sb.size()); else n_pass++;
  endtask

  task automatic test_single();
    int npl;
    do_reset();
    run_window("single", 20, 10, 10, -1, -1, -1, -1, npl);
    n_chk++; if (npl != 1) $display("FAIL single.count got=%0d exp=1", npl); else n_pass++;
  endtask

  task automatic test_burst();
    int npl;
    do_reset();
    run_window("burst", 26, 10, 12, -1, -1, -1, -1, npl);
    n_chk++; if (npl != 3) $display("FAIL burst.count got=%0d exp=3", npl); else n_pass++;
  endtask

  task automatic test_saturate();
    int npl;
    do_reset();
    run_window("saturate", 56, 10, 21, -1, -1, -1, -1, npl);
    n_chk++; if (npl != 10) $display("FAIL saturate.count got=%0d exp=10", npl); else n_pass++;
    n_chk++; if (ovf1 !== 1'b1) $display("FAIL saturate.sticky got=%0b exp=1", ovf1); else n_pass++;
    n_chk++; if (pend1 !== 3'd0) $display("FAIL saturate.drained got=%0d exp=0", pend1); else n_pass++;
  endtask

  // Saturate, clear with no drop at 60, then saturate again with the clear
  // landing on the first dropped event (cycle 80).
  task automatic test_ovf_clr();
    int npl;
    do_reset();
    run_window("ovf_clr", 112, 10, 21, 70, 80, 60, 80, npl);
    n_chk++; if (npl != 20) $display("FAIL ovf_clr.count got=%0d exp=20", npl); else n_pass++;
    n_chk++; if (ovf1 !== 1'b1) $display("FAIL ovf_clr.set_wins got=%0b exp=1", ovf1); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit hit;
    int npl;
    do_reset();
    hit = 1'b0;
    for (int c = 0; c < 40 && !hit; c++) begin
      drive_cycle(c, 4, c >= 10, 1'b0);
      @(negedge clk);
      n_chk++; if (pend1 !== 3'(exp_pend)) $display("FAIL rst_mid.pending c=%0d got=%0d exp=%0d", c, pend1, exp_pend); else n_pass++;
      if (exp_pend == 5) hit = 1'b1;
      else begin @(posedge clk); #1; end
    end
    n_chk++; if (!hit) $display("FAIL rst_mid.reach5 got=0 exp=1 (pending never reached 5)"); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_chk++; if (flag1 !== 1'b0) $display("FAIL rst_mid.flag got=%0b exp=0", flag1);  else n_pass++;
    n_chk++; if (pend1 !== 3'd0) $display("FAIL rst_mid.pending got=%0d exp=0", pend1); else n_pass++;
    n_chk++; if (ovf1 !== 1'b0)  $display("FAIL rst_mid.overflow got=%0b exp=0", ovf1); else n_pass++;
    n_chk++; if (busy1 !== 1'b0) $display("FAIL rst_mid.busy got=%0b exp=0", busy1);  else n_pass++;
    evt1 = 1'b0;
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    run_window("rst_mid", 16, 0, 0, -1, -1, -1, -1, npl);
    n_chk++; if (npl != 1) $display("FAIL rst_mid.count got=%0d exp=1", npl); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int npl, prev;
    do_reset();
    npl  = 0;
    prev = -100;
    for (int c = 0; c < 20; c++) begin
      drive_cycle(c, 2, c >= 2 && c <= 7, 1'b0);
      @(negedge clk);
      n_chk++;
      if (sb.size() != 0 && sb[0] == c) begin
        sb.delete(0);
        if (flag2 !== 1'b1) $display("FAIL b2b.flag c=%0d got=%0b exp=1", c, flag2); else n_pass++;
      end else begin
        if (flag2 !== 1'b0) $display("FAIL b2b.flag c=%0d got=%0b exp=0", c, flag2); else n_pass++;
      end
      if (flag2 === 1'b1) begin
        npl++;
        n_chk++; if (c - prev < 2) $display("FAIL b2b.spacing c=%0d got=%0d exp>=2", c, c - prev); else n_pass++;
        prev = c;
      end
      n_chk++; if (pend2 !== 3'(exp_pend)) $display("FAIL b2b.pending c=%0d got=%0d exp=%0d", c, pend2, exp_pend); else n_pass++;
      n_chk++; if (busy2 !== exp_busy) $display("FAIL b2b.busy c=%0d got=%0b exp=%0b", c, busy2, exp_busy); else n_pass++;
      n_chk++; if (ovf2 !== exp_ovf) $display("FAIL b2b.overflow c=%0d got=%0b exp=%0b", c, ovf2, exp_ovf); else n_pass++;
      @(posedge clk); #1;
    end
    n_chk++; if (npl != 6) $display("FAIL b2b.count got=%0d exp=6", npl); else n_pass++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_saturate();
    test_ovf_clr();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
